player_physics: RTL and testbench
=================================

Name: player_physics

Overview:
- Per-frame player velocity update stage; sits directly upstream of the move/collision stage.
- On each frame strobe, applies run acceleration, friction, gravity, jump (with buffer and coyote grace) and dash to the player speed.
- Outputs the new speed (vec2d, signed 16.16 per axis) for the move stage to consume.
- Takes the move stage's post-collision spd_o back as spd_i, so collision zeroing carries into the next frame.

Parameters:
- MAX_DJUMP, 1, dashes restored on ground contact (1..3)
- JBUF_FRAMES, 4, jump buffer length in frames
- GRACE_FRAMES, 6, coyote grace length in frames
- DASH_FRAMES, 4, frames speed is frozen after a dash

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- frame_i  in  1  one-cycle frame strobe
- btn_i  in  6  {left,right,up,down,jump,dash}, sampled on frame_i
- on_ground_i  in  1  solid directly below player, sampled on frame_i
- spd_i  in  vec2d  current speed, fed back from the move stage, sampled on frame_i
- spd_o  out  vec2d  updated speed, stable from valid_o until the next update
- valid_o  out  1  one-cycle pulse: spd_o updated
- djump_o  out  2  dashes remaining
- dashing_o  out  1  dash freeze active
- flip_o  out  1  facing: 1 = left

Behaviour:
- Reset (rst_i high on any clock, including mid-update):
  - FSM to IDLE; spd_o=0, valid_o=0, dashing_o=0, flip_o=0, djump_o=MAX_DJUMP.
  - jbuf, grace, dash_cnt, jump_prev, dash_prev all cleared to 0.
- FSM IDLE -> RUN -> VERT -> DASH -> DONE -> IDLE, one state per cycle.
  - frame_i at cycle N gives valid_o high at N+4, then returns to IDLE.
  - frame_i outside IDLE is ignored.
- IDLE, on frame_i:
  - Latch spd_i, btn_i, on_ground_i.
  - jpress = jump & !jump_prev; dpress = dash & !dash_prev. Then update jump_prev and dash_prev.
  - jbuf: jpress ? JBUF_FRAMES : (jbuf>0 ? jbuf-1 : 0).
  - grace: on_ground ? GRACE_FRAMES : (grace>0 ? grace-1 : 0).
  - on_ground sets djump = MAX_DJUMP.
- appr(v,t,a) = v>t ? max(v-a,t) : min(v+a,t). All math is 32-bit signed 16.16; values are bounded, so no saturation.
- RUN (skipped if dash_cnt>0):
  - dir = -1 for left only, +1 for right only, 0 for neither or both.
  - accel = on_ground ? 0x00009999 (0.6) : 0x00006666 (0.4).
  - If |x| > 0x00010000: x = appr(x, sign(x)*0x00010000, 0x00002666).
  - Else: x = appr(x, dir*0x00010000, accel).
  - dir != 0 updates flip_o.
- VERT (skipped if dash_cnt>0):
  - If !on_ground: g = 0x000035C3 (0.21), halved to 0x00001AE1 when |y| <= 0x00002666; y = appr(y, 0x00020000, g).
  - Then, if jbuf>0 and grace>0: y = 0xFFFE0000 (-2.0), jbuf=0, grace=0.
- DASH:
  - If dash_cnt>0: dash_cnt-1, no speed change.
  - Else if dpress and djump>0: djump-1, dash_cnt = DASH_FRAMES.
    - Direction from the buttons; up has priority over down.
    - Axis-only: speed 0x00050000 on that axis, other axis 0.
    - Diagonal: 0x00038918 (3.5355) on both axes.
    - No direction pressed: x = flip ? -5.0 : +5.0, y = 0.
  - A dash in the same frame as a jump overrides the jump's speed. The jump's buffer and grace are still consumed.
  - dpress with djump=0: ignored; the edge is lost, not buffered.
- DONE: drive spd_o and djump_o; dashing_o = (dash_cnt>0); valid_o=1.

Test Plan:
- Reset, then frame_i with spd_i=0, right held, grounded -> valid_o 4 cycles later; spd_o.x=0x00009999, spd_o.y=0.
- spd_i.x=0x00030000, no input, airborne, spd_i.y=0 -> spd_o.x=0x0002D99A, spd_o.y=0x00001AE1.
- Jump pressed on frame k while airborne with grace=0, grounded on frame k+2 -> spd_o.y=0xFFFE0000 at k+2; jump held at k+3 gives no second jump.
- Walk off ledge (grounded frame 0, airborne frames 1..7), press jump at frame 5 -> jumps; same press at frame 7 -> no jump.
- Dash with right+up, djump=1 -> spd_o=(0x00038918,0xFFFC76E8), djump_o=0, dashing_o=1 for 4 frames with speed unchanged; a second dash press does nothing until grounded.
- rst_i asserted one cycle after frame_i -> no valid_o pulse; all outputs at reset values the next cycle.

Source files
------------

// File: rtl/player_physics.sv
// Per-frame player velocity update: run, friction, gravity, buffered/coyote
// jump and dash. Speed vectors are {x[63:32], y[31:0]}, signed 16.16 per axis.
//
// state | meaning
// IDLE  | wait for frame_i; latch inputs, age jump buffer and coyote timer
// RUN   | horizontal accel/friction, facing update (skipped while dashing)
// VERT  | gravity, then buffered jump if still within coyote grace (skipped while dashing)
// DASH  | dash freeze countdown or new dash; result registered to outputs
// DONE  | outputs presented, valid_o high for this single cycle
module player_physics #(
    parameter int MAX_DJUMP    = 1,
    parameter int JBUF_FRAMES  = 4,
    parameter int GRACE_FRAMES = 6,
    parameter int DASH_FRAMES  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        frame_i,
    input  logic [5:0]  btn_i,
    input  logic        on_ground_i,
    input  logic [63:0] spd_i,
    output logic [63:0] spd_o,
    output logic        valid_o,
    output logic [1:0]  djump_o,
    output logic        dashing_o,
    output logic        flip_o
);

    localparam int JW = $clog2(JBUF_FRAMES + 1);
    localparam int GW = $clog2(GRACE_FRAMES + 1);
    localparam int DW = $clog2(DASH_FRAMES + 1);

    localparam logic signed [31:0] ONE      = 32'sh0001_0000;
    localparam logic signed [31:0] NEG_ONE  = 32'shFFFF_0000;
    localparam logic signed [31:0] DECEL    = 32'sh0000_2666;
    localparam logic signed [31:0] ACC_GND  = 32'sh0000_9999;
    localparam logic signed [31:0] ACC_AIR  = 32'sh0000_6666;
    localparam logic signed [31:0] G_FULL   = 32'sh0000_35C3;
    localparam logic signed [31:0] G_HALF   = 32'sh0000_1AE1;
    localparam logic signed [31:0] APEX     = 32'sh0000_2666;
    localparam logic signed [31:0] NEG_APEX = 32'shFFFF_D99A;
    localparam logic signed [31:0] MAX_FALL = 32'sh0002_0000;
    localparam logic signed [31:0] JUMP_Y   = 32'shFFFE_0000;
    localparam logic signed [31:0] DASH_AX  = 32'sh0005_0000;
    localparam logic signed [31:0] DASH_DG  = 32'sh0003_8918;

    typedef enum logic [2:0] {IDLE, RUN, VERT, DASH, DONE} state_t;

    // Move v toward t by at most a, never overshooting t.
    function automatic logic signed [31:0] appr(input logic signed [31:0] v,
                                                input logic signed [31:0] t,
                                                input logic signed [31:0] a);
        logic signed [31:0] r;
        if (v > t) begin
            r = v - a;
            if (r < t) r = t;
        end else begin
            r = v + a;
            if (r > t) r = t;
        end
        return r;
    endfunction

    state_t             state_q;
    logic signed [31:0] x_q, y_q;
    logic               left_q, right_q, up_q, down_q;
    logic               gnd_q, dpress_q;
    logic               jump_prev_q, dash_prev_q;
    logic [JW-1:0]      jbuf_q;
    logic [GW-1:0]      grace_q;
    logic [DW-1:0]      dash_cnt_q;
    logic [1:0]         djump_q;
    logic [63:0]        spd_q;
    logic               valid_q, dashing_q, flip_q, djump_o_unused;
    logic [1:0]         djump_out_q;

    logic               jpress_d;
    logic               left_only, right_only, frozen;
    logic signed [31:0] run_x_d, vert_y_d, dash_x_d, dash_y_d, grav_y, accel, dir_tgt, grav;
    logic               jump_now, dash_start, h_dir, v_dir;
    logic signed [31:0] dash_mag;

    assign spd_o          = spd_q;
    assign valid_o        = valid_q;
    assign djump_o        = djump_out_q;
    assign dashing_o      = dashing_q;
    assign flip_o         = flip_q;
    assign djump_o_unused = 1'b0;

    // Per-stage arithmetic, evaluated from the latched frame state.
    always_comb begin
        jpress_d   = btn_i[1] & ~jump_prev_q;
        frozen     = (dash_cnt_q != '0);
        left_only  = left_q & ~right_q;
        right_only = right_q & ~left_q;

        accel   = gnd_q ? ACC_GND : ACC_AIR;
        dir_tgt = left_only ? NEG_ONE : (right_only ? ONE : 32'sh0);
        if (x_q > ONE)          run_x_d = appr(x_q, ONE, DECEL);
        else if (x_q < NEG_ONE) run_x_d = appr(x_q, NEG_ONE, DECEL);
        else                    run_x_d = appr(x_q, dir_tgt, accel);

        grav     = (y_q <= APEX && y_q >= NEG_APEX) ? G_HALF : G_FULL;
        grav_y   = gnd_q ? y_q : appr(y_q, MAX_FALL, grav);
        jump_now = (jbuf_q != '0) && (grace_q != '0);
        vert_y_d = jump_now ? JUMP_Y : grav_y;

        dash_start = ~frozen & dpress_q & (djump_q != 2'd0);
        h_dir      = left_only | right_only;
        v_dir      = up_q | down_q;
        dash_mag   = (h_dir && v_dir) ? DASH_DG : DASH_AX;
        if (!h_dir && !v_dir) begin
            dash_x_d = flip_q ? -DASH_AX : DASH_AX;
            dash_y_d = 32'sh0;
        end else begin
            dash_x_d = left_only ? -dash_mag : (right_only ? dash_mag : 32'sh0);
            // up wins over down when both are held
            dash_y_d = up_q ? -dash_mag : (down_q ? dash_mag : 32'sh0);
        end
    end

    // Frame-update FSM with registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            gnd_q       <= 1'b0;
            dpress_q    <= 1'b0;
            jump_prev_q <= 1'b0;
            dash_prev_q <= 1'b0;
            jbuf_q      <= '0;
            grace_q     <= '0;
            dash_cnt_q  <= '0;
            djump_q     <= 2'(MAX_DJUMP);
            djump_out_q <= 2'(MAX_DJUMP);
            spd_q       <= '0;
            valid_q     <= 1'b0;
            dashing_q   <= 1'b0;
            flip_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_i) begin
                        x_q         <= spd_i[63:32];
                        y_q         <= spd_i[31:0];
                        left_q      <= btn_i[5];
                        right_q     <= btn_i[4];
                        up_q        <= btn_i[3];
                        down_q      <= btn_i[2];
                        gnd_q       <= on_ground_i;
                        dpress_q    <= btn_i[0] & ~dash_prev_q;
                        jump_prev_q <= btn_i[1];
                        dash_prev_q <= btn_i[0];
                        if (jpress_d)           jbuf_q <= JW'(JBUF_FRAMES);
                        else if (jbuf_q != '0)  jbuf_q <= jbuf_q - JW'(1);
                        if (on_ground_i)        grace_q <= GW'(GRACE_FRAMES);
                        else if (grace_q != '0) grace_q <= grace_q - GW'(1);
                        if (on_ground_i)        djump_q <= 2'(MAX_DJUMP);
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (!frozen) begin
                        x_q <= run_x_d;
                        if (left_only)  flip_q <= 1'b1;
                        if (right_only) flip_q <= 1'b0;
                    end
                    state_q <= VERT;
                end
                VERT: begin
                    if (!frozen) begin
                        y_q <= vert_y_d;
                        if (jump_now) begin
                            jbuf_q  <= '0;
                            grace_q <= '0;
                        end
                    end
                    state_q <= DASH;
                end
                DASH: begin
                    if (frozen) begin
                        dash_cnt_q <= dash_cnt_q - DW'(1);
                        dashing_q  <= (dash_cnt_q != DW'(1));
                        spd_q      <= {x_q, y_q};
                        djump_out_q <= djump_q;
                    end else if (dash_start) begin
                        dash_cnt_q  <= DW'(DASH_FRAMES);
                        dashing_q   <= 1'b1;
                        djump_q     <= djump_q - 2'd1;
                        djump_out_q <= djump_q - 2'd1;
                        x_q         <= dash_x_d;
                        y_q         <= dash_y_d;
                        spd_q       <= {dash_x_d, dash_y_d};
                    end else begin
                        dashing_q   <= 1'b0;
                        spd_q       <= {x_q, y_q};
                        djump_out_q <= djump_q;
                    end
                    valid_q <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_player_physics.sv
// Directed frame vectors for player_physics; expected responses go to a
// queue and a monitor compares them against each valid_o pulse.
module tb_player_physics;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        frame_i;
    logic [5:0]  btn_i;
    logic        on_ground_i;
    logic [63:0] spd_i;
    logic [63:0] spd_o;
    logic        valid_o;
    logic [1:0]  djump_o;
    logic        dashing_o;
    logic        flip_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] x;
        logic [31:0] y;
        logic [1:0]  dj;
        logic        dash;
        logic        flip;
    } exp_t;

    exp_t exp_q[$];

    player_physics dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .frame_i    (frame_i),
        .btn_i      (btn_i),
        .on_ground_i(on_ground_i),
        .spd_i      (spd_i),
        .spd_o      (spd_o),
        .valid_o    (valid_o),
        .djump_o    (djump_o),
        .dashing_o  (dashing_o),
        .flip_o     (flip_o)
    );

    always #5 clk = ~clk;

    // btn encodings {left,right,up,down,jump,dash}
    localparam logic [5:0] B_NONE  = 6'b000000;
    localparam logic [5:0] B_LEFT  = 6'b100000;
    localparam logic [5:0] B_RIGHT = 6'b010000;
    localparam logic [5:0] B_JUMP  = 6'b000010;
    localparam logic [5:0] B_DASH  = 6'b000001;
    localparam logic [5:0] B_RUD   = 6'b011001;

    // monitor: every valid_o pulse must match the oldest expectation
    always @(negedge clk) begin
        if (valid_o) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got spd=%h dj=%0d dash=%0d flip=%0d, required no pulse",
                         spd_o, djump_o, dashing_o, flip_o);
            end else begin
                e = exp_q.pop_front();
                if (spd_o !== {e.x, e.y} || djump_o !== e.dj || dashing_o !== e.dash || flip_o !== e.flip) begin
                    errors++;
                    $display("FAIL %s: got x=%h y=%h dj=%0d dash=%0d flip=%0d, required x=%h y=%h dj=%0d dash=%0d flip=%0d",
                             e.name, spd_o[63:32], spd_o[31:0], djump_o, dashing_o, flip_o,
                             e.x, e.y, e.dj, e.dash, e.flip);
                end
            end
        end
    end

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
    endtask

    task automatic check_reset(input string name);
        checks++;
        if (spd_o !== 64'h0 || valid_o !== 1'b0 || dashing_o !== 1'b0 || flip_o !== 1'b0 || djump_o !== 2'd1) begin
            errors++;
            $display("FAIL %s: got spd=%h valid=%0d dash=%0d flip=%0d dj=%0d, required spd=0 valid=0 dash=0 flip=0 dj=1",
                     name, spd_o, valid_o, dashing_o, flip_o, djump_o);
        end
    endtask

    task automatic do_frame(input string name, input logic [5:0] btn, input logic gnd,
                            input logic [31:0] sx, input logic [31:0] sy,
                            input logic [31:0] ex, input logic [31:0] ey,
                            input logic [1:0] edj, input logic edash, input logic eflip,
                            input bit hold = 1'b0);
        exp_t e;
        int   lat;
        e.name = name; e.x = ex; e.y = ey; e.dj = edj; e.dash = edash; e.flip = eflip;
        exp_q.push_back(e);
        @(negedge clk);
        btn_i = btn; on_ground_i = gnd; spd_i = {sx, sy}; frame_i = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        if (hold) begin
            @(posedge clk); #1;
            lat = 2;
        end
        frame_i = 1'b0;
        while (!valid_o && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != 4 || !valid_o) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles (valid=%0d), required 4", name, lat, valid_o);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        frame_i = 1'b0; btn_i = B_NONE; on_ground_i = 1'b0; spd_i = '0;
        do_reset();
        check_reset("reset_state");

        // run accel, facing; second frame holds frame_i for two cycles
        do_frame("run_right", B_RIGHT, 1'b1, 32'h0, 32'h0, 32'h00009999, 32'h0, 2'd1, 1'b0, 1'b0);
        do_frame("run_left_hold", B_LEFT, 1'b1, 32'h00009999, 32'h0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b1, 1'b1);

        // friction above max run speed plus half gravity near apex
        do_reset();
        do_frame("friction_air", B_NONE, 1'b0, 32'h00030000, 32'h0, 32'h0002D99A, 32'h00001AE1, 2'd1, 1'b0, 1'b0);

        // jump buffer: pressed airborne, lands two frames later
        do_reset();
        do_frame("jbuf_k0", B_JUMP, 1'b0, 32'h0, 32'h0,        32'h0, 32'h00001AE1, 2'd1, 1'b0, 1'b0);
        do_frame("jbuf_k1", B_JUMP, 1'b0, 32'h0, 32'h00001AE1, 32'h0, 32'h000035C2, 2'd1, 1'b0, 1'b0);
        do_frame("jbuf_k2", B_JUMP, 1'b1, 32'h0, 32'h000035C2, 32'h0, 32'hFFFE0000, 2'd1, 1'b0, 1'b0);
        do_frame("jbuf_k3", B_JUMP, 1'b1, 32'h0, 32'hFFFE0000, 32'h0, 32'hFFFE0000, 2'd1, 1'b0, 1'b0);

        // coyote grace: jump on 5th airborne frame succeeds
        do_reset();
        do_frame("coy_f0", B_NONE, 1'b1, 32'h0, 32'h0,        32'h0, 32'h0,        2'd1, 1'b0, 1'b0);
        do_frame("coy_f1", B_NONE, 1'b0, 32'h0, 32'h0,        32'h0, 32'h00001AE1, 2'd1, 1'b0, 1'b0);
        do_frame("coy_f2", B_NONE, 1'b0, 32'h0, 32'h00001AE1, 32'h0, 32'h000035C2, 2'd1, 1'b0, 1'b0);
        do_frame("coy_f3", B_NONE, 1'b0, 32'h0, 32'h000035C2, 32'h0, 32'h00006B85, 2'd1, 1'b0, 1'b0);
        do_frame("coy_f4", B_NONE, 1'b0, 32'h0, 32'h00006B85, 32'h0, 32'h0000A148, 2'd1, 1'b0, 1'b0);
        do_frame("coy_f5", B_JUMP, 1'b0, 32'h0, 32'h0000A148, 32'h0, 32'hFFFE0000, 2'd1, 1'b0, 1'b0);

        // grace expired: jump on 7th airborne frame is ignored
        do_reset();
        do_frame("late_f0", B_NONE, 1'b1, 32'h0, 32'h0,        32'h0, 32'h0,        2'd1, 1'b0, 1'b0);
        do_frame("late_f1", B_NONE, 1'b0, 32'h0, 32'h0,        32'h0, 32'h00001AE1, 2'd1, 1'b0, 1'b0);
        do_frame("late_f2", B_NONE, 1'b0, 32'h0, 32'h00001AE1, 32'h0, 32'h000035C2, 2'd1, 1'b0, 1'b0);
        do_frame("late_f3", B_NONE, 1'b0, 32'h0, 32'h000035C2, 32'h0, 32'h00006B85, 2'd1, 1'b0, 1'b0);
        do_frame("late_f4", B_NONE, 1'b0, 32'h0, 32'h00006B85, 32'h0, 32'h0000A148, 2'd1, 1'b0, 1'b0);
        do_frame("late_f5", B_NONE, 1'b0, 32'h0, 32'h0000A148, 32'h0, 32'h0000D70B, 2'd1, 1'b0, 1'b0);
        do_frame("late_f6", B_NONE, 1'b0, 32'h0, 32'h0000D70B, 32'h0, 32'h00010CCE, 2'd1, 1'b0, 1'b0);
        do_frame("late_f7", B_JUMP, 1'b0, 32'h0, 32'h00010CCE, 32'h0, 32'h00014291, 2'd1, 1'b0, 1'b0);

        // diagonal dash, freeze, re-dash refused until grounded
        do_reset();
        do_frame("dash_f0", B_RUD, 1'b0, 32'h0, 32'h0, 32'h00038918, 32'hFFFC76E8, 2'd0, 1'b1, 1'b0);
        do_frame("dash_f1", B_RUD, 1'b0, 32'h00038918, 32'hFFFC76E8, 32'h00038918, 32'hFFFC76E8, 2'd0, 1'b1, 1'b0);
        do_frame("dash_f2", B_RUD, 1'b0, 32'h00038918, 32'hFFFC76E8, 32'h00038918, 32'hFFFC76E8, 2'd0, 1'b1, 1'b0);
        do_frame("dash_f3", B_RUD, 1'b0, 32'h00038918, 32'hFFFC76E8, 32'h00038918, 32'hFFFC76E8, 2'd0, 1'b1, 1'b0);
        do_frame("dash_f4", B_RUD, 1'b0, 32'h00038918, 32'hFFFC76E8, 32'h00038918, 32'hFFFC76E8, 2'd0, 1'b0, 1'b0);
        do_frame("dash_f5", B_NONE, 1'b0, 32'h00038918, 32'hFFFC76E8, 32'h000362B2, 32'hFFFCACAB, 2'd0, 1'b0, 1'b0);
        do_frame("dash_f6_nodj", B_DASH, 1'b0, 32'h000362B2, 32'hFFFCACAB, 32'h00033C4C, 32'hFFFCE26E, 2'd0, 1'b0, 1'b0);
        do_frame("dash_f7_land", B_NONE, 1'b1, 32'h00033C4C, 32'hFFFCE26E, 32'h000315E6, 32'hFFFCE26E, 2'd1, 1'b0, 1'b0);
        do_frame("dash_f8_facing", B_DASH, 1'b1, 32'h000315E6, 32'hFFFCE26E, 32'h00050000, 32'h0, 2'd0, 1'b1, 1'b0);

        // reset one cycle after frame_i aborts the update
        do_reset();
        do_frame("pre_abort", B_LEFT, 1'b1, 32'h0, 32'h0, 32'hFFFF6667, 32'h0, 2'd1, 1'b0, 1'b1);
        @(negedge clk);
        btn_i = B_RUD; on_ground_i = 1'b0; spd_i = '0; frame_i = 1'b1;
        @(posedge clk); #1;
        frame_i = 1'b0; rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        check_reset("abort_reset_values");
        repeat (8) @(posedge clk);
        #1;
        check_reset("abort_no_pulse");
        do_frame("post_abort", B_RIGHT, 1'b1, 32'h0, 32'h0, 32'h00009999, 32'h0, 2'd1, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
